// File: rtl/control_multicycle.sv
// Multicycle MIPS control unit: Moore FSM with memory-ready stalls and a retired-instruction counter.
// Define CTRL_IMM_EN to enable the addi/andi/ori/slti path (IMM_EXEC/IMM_WB states).
module control_multicycle #(
  parameter int ALU_CTRL_W = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            op,
  input  logic [5:0]            funct,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  pc_write_cond,
  output logic                  i_or_d,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  mem_to_reg,
  output logic                  reg_dest,
  output logic                  reg_write,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            pc_src,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [3:0]            state,
  output logic                  instr_done,
  output logic                  illegal,
  output logic [CNT_W-1:0]      instr_cnt
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_IMM_EXEC = 4'd10,
    S_IMM_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [3:0]       alu_op;

  // The zero flag is consumed by the datapath together with pc_write_cond.
  logic unused_zero;
  assign unused_zero = zero;

  always_comb begin
    state_next    = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dest      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    alu_op        = 4'b0000;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b01;
        alu_op     = ALU_ADD;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        state_next = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
        case (op)
          OP_RTYPE:     state_next = S_EXEC;
          OP_LW, OP_SW: state_next = S_MEM_ADDR;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
`ifdef CTRL_IMM_EN
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = S_IMM_EXEC;
`endif
          default: begin
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_op     = ALU_ADD;
        state_next = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read   = 1'b1;
        i_or_d     = 1'b1;
        state_next = mem_ready ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
        state_next = mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        state_next = S_R_WB;
        case (funct)
          6'b100000: alu_op = ALU_ADD;
          6'b100010: alu_op = ALU_SUB;
          6'b100100: alu_op = ALU_AND;
          6'b100101: alu_op = ALU_OR;
          6'b101010: alu_op = ALU_SLT;
          6'b100111: alu_op = ALU_NOR;
          default: begin
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dest   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        instr_done = 1'b1;
      end
`ifdef CTRL_IMM_EN
      S_IMM_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = S_IMM_WB;
        case (op)
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          OP_SLTI: alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      S_IMM_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
`endif
      default: state_next = S_FETCH;
    endcase
    // Reset abandons the instruction in flight: no strobe may leak out.
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dest      = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      pc_src        = 2'b00;
      alu_op        = 4'b0000;
      instr_done    = 1'b0;
      illegal       = 1'b0;
    end
  end

  always_comb begin
    alu_ctrl      = '0;
    alu_ctrl[3:0] = alu_op;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (instr_done) cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign state     = state_reg;
  assign instr_cnt = cnt_reg;

endmodule

// File: doc/control_multicycle.md
# control_multicycle

Multicycle MIPS control unit: the sequential successor to the single-cycle `control` decoder. It steps each instruction through a Moore FSM (fetch, decode, execute, memory, writeback) and emits per-cycle datapath strobes from the current state. It stalls on a memory ready handshake and counts retired instructions. It sits between the instruction register and the shared-memory multicycle datapath.

## Interface
Parameters:
- ALU_CTRL_W, 4 — width of `alu_ctrl`; must be >= 4; bits above [3:0] driven 0.
- CNT_W, 32 — width of retired-instruction counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- op  in  6  opcode from IR; valid from DECODE onward.
- funct  in  6  function field from IR.
- zero  in  1  ALU zero flag (datapath consumes it with `pc_write_cond`).
- mem_ready  in  1  memory completes current read/write this cycle.
- pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dest, reg_write, alu_src_a  out  1 each  datapath strobes.
- alu_src_b  out  2  00 = regB, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2.
- pc_src  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target.
- alu_ctrl  out  ALU_CTRL_W  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
- state  out  4  current FSM state.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal  out  1  one-cycle pulse on an unsupported op/funct.
- instr_cnt  out  CNT_W  retired-instruction count.

## Operation
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, R_WB=7, BRANCH=8, JUMP=9, IMM_EXEC=10, IMM_WB=11. Codes 12–15 go to FETCH on the next edge.
- Outputs not listed for a state are 0.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ADD.
  - ir_write and pc_write equal mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, ADD. Next state by op:
  - 000000 → EXEC
  - 100011 (lw) or 101011 (sw) → MEM_ADDR
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - 001000 / 001100 / 001101 / 001010 (addi/andi/ori/slti) → IMM_EXEC
  - anything else → FETCH with illegal=1
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. Waits for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dest=0, instr_done=1. Then FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Waits for mem_ready; instr_done=1 in the ready cycle, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00. ALU op by funct:
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100111 NOR.
  - Any other funct: illegal=1, go to FETCH with no writeback.
- R_WB: reg_write=1, reg_dest=1, instr_done=1. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_write_cond=1, pc_src=01, instr_done=1. Then FETCH.
- JUMP: pc_write=1, pc_src=10, instr_done=1. Then FETCH.
- IMM_EXEC: alu_src_a=1, alu_src_b=10. ALU op: addi→ADD, andi→AND, ori→OR, slti→SLT. Then IMM_WB.
- IMM_WB: reg_write=1, reg_dest=0, mem_to_reg=0, instr_done=1. Then FETCH.
- instr_cnt: increments by 1 on every instr_done cycle and wraps modulo 2^CNT_W. Illegal instructions are not counted.

## Timing
- Reset: state=FETCH on the edge where rst=1, and instr_cnt=0. While rst=1, every strobe, instr_done and illegal are forced to 0.
- A reset mid-instruction abandons it; no partial writes are issued after the reset edge.
- Strobes are combinational from `state` (plus mem_ready in the wait states). `state` and `instr_cnt` are registered.
- Latency with mem_ready held at 1:
  - lw: 5 cycles
  - R-type, sw, I-type: 4 cycles
  - beq, j: 3 cycles
- Each cycle mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle. Strobes hold steady while waiting.
- mem_ready is ignored in every other state.

## Configuration
- `CTRL_IMM_EN` defined: the IMM_EXEC and IMM_WB path exists as described.
- `CTRL_IMM_EN` undefined: opcodes 001000/001100/001101/001010 decode as illegal, states 10–11 are unreachable and treated as invalid codes (→ FETCH).

## Test plan
- Reset mid-MEM_RD, then release → state=0, instr_cnt=0, all strobes 0 during reset; FETCH resumes with mem_read=1.
- lw (op=100011), mem_ready=1 → state sequence 0,1,2,3,4; instr_done high only in state 4; instr_cnt=1.
- R-type funct=100010, mem_ready low for 2 FETCH cycles → FETCH held 3 cycles with ir_write=0 until ready; alu_ctrl=0110 in EXEC; reg_dest=1 in R_WB.
- beq then j → BRANCH: pc_write_cond=1, pc_src=01, alu_ctrl=0110; JUMP: pc_write=1, pc_src=10; instr_cnt +2.
- op=111111, then R-type funct=000000 → illegal pulse once each, no reg_write, instr_cnt unchanged.
- With `CTRL_IMM_EN`, ori → alu_ctrl=0001, alu_src_b=10, reg_write in state 11. Without it, ori → illegal=1.
